// File: rtl/dmem_responder.sv
`default_nettype none
// =============================================================================
// dmem_responder : load/store data-memory slave with RAM, cycle counter, LEDs
// Revision 1.0
// =============================================================================
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] led_out
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] LED_ADDR  = MMIO_BASE + 32'd4;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] led_q, led_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] ram [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        use_live;
    logic [31:0] acc_addr;
    logic        acc_we;
    logic [2:0]  acc_f3;
    logic [31:0] acc_wdata;
    logic [1:0]  lane;
    logic [AW-1:0] ram_idx;
    logic        hit_ram, hit_cnt, hit_led;
    logic        f3_byte, f3_word;
    logic        acc_err;
    logic [31:0] src_word, src_shift;
    logic [7:0]  sel_byte;
    logic [31:0] load_val;
    logic [3:0]  wr_mask;
    logic [31:0] wr_word;
    logic        ram_we, led_we;

    assign accept = (state_q == S_IDLE) && req_valid;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= 32'd0;
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            wdata_q    <= 32'd0;
            cycle_q    <= 32'd0;
            led_q      <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            wdata_q    <= wdata_d;
            cycle_q    <= cycle_d;
            led_q      <= led_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Zero wait states commit on the accept edge, so decode the live request then
    always_comb begin
        addr_d    = accept ? req_addr   : addr_q;
        we_d      = accept ? req_we     : we_q;
        funct3_d  = accept ? req_funct3 : funct3_q;
        wdata_d   = accept ? req_wdata  : wdata_q;

        use_live  = (state_q == S_IDLE);
        acc_addr  = use_live ? req_addr   : addr_q;
        acc_we    = use_live ? req_we     : we_q;
        acc_f3    = use_live ? req_funct3 : funct3_q;
        acc_wdata = use_live ? req_wdata  : wdata_q;
        commit    = (state_d == S_RESP) && (state_q != S_RESP);

        lane      = acc_addr[1:0];
        ram_idx   = acc_addr[AW+1:2];
        hit_cnt   = ({acc_addr[31:2], 2'b00} == MMIO_BASE);
        hit_led   = ({acc_addr[31:2], 2'b00} == LED_ADDR);
        hit_ram   = (acc_addr < RAM_BYTES) && !hit_cnt && !hit_led;
        f3_byte   = (acc_f3 == 3'b000) || (acc_f3 == 3'b100);
        f3_word   = (acc_f3 == 3'b010);
        acc_err   = !(f3_byte || f3_word) ||
                    (f3_word && (lane != 2'b00)) ||
                    !(hit_ram || hit_cnt || hit_led) ||
                    (acc_we && (acc_f3 == 3'b100));

        src_word  = hit_cnt ? cycle_q : (hit_led ? led_q : ram[ram_idx]);
        src_shift = src_word >> {lane, 3'b000};
        sel_byte  = src_shift[7:0];
        case (acc_f3)
            3'b010:  load_val = src_word;
            3'b100:  load_val = {24'd0, sel_byte};
            default: load_val = {{24{sel_byte[7]}}, sel_byte};
        endcase

        wr_mask   = f3_word ? 4'hF : (4'b0001 << lane);
        wr_word   = f3_word ? acc_wdata : {4{acc_wdata[7:0]}};
        ram_we    = commit && !acc_err && acc_we && hit_ram;
        led_we    = commit && !acc_err && acc_we && hit_led;

        cycle_d   = cycle_q + 32'd1;
        led_d     = led_q;
        for (int b = 0; b < 4; b++) begin
            if (led_we && wr_mask[b]) begin
                led_d[8*b +: 8] = wr_word[8*b +: 8];
            end
        end

        rdata_d   = rdata_q;
        err_d     = err_q;
        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_we) ? 32'd0 : load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    ram[ram_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // Output logic
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        led_out   = led_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// =============================================================================
// tb_dmem_responder : directed bench for dmem_responder at 0, 1 and 3 wait states
// Revision 1.0
// =============================================================================
module tb_dmem_responder;

    localparam logic [31:0] MB = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;

    logic        ready0, rv0, re0;
    logic [31:0] rd0, led0;
    logic        ready1, rv1, re1;
    logic [31:0] rd1, led1;
    logic        ready3, rv3, re3;
    logic [31:0] rd3, led3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .MMIO_BASE(MB)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
        .req_addr(req_addr), .req_we(req_we), .req_funct3(req_funct3),
        .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_rdata(rd0),
        .rsp_err(re0), .led_out(led0));

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .MMIO_BASE(MB)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
        .req_addr(req_addr), .req_we(req_we), .req_funct3(req_funct3),
        .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1),
        .rsp_err(re1), .led_out(led1));

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .MMIO_BASE(MB)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3),
        .req_addr(req_addr), .req_we(req_we), .req_funct3(req_funct3),
        .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3),
        .rsp_err(re3), .led_out(led3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request to the 1-wait-state instance; called at posedge+1 while it is idle
    task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        lat = -1;
        rd  = 32'd0;
        er  = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            if (rv1 === 1'b1) begin
                lat = i;
                rd  = rd1;
                er  = re1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat >= 0) begin
            @(posedge clk);
            #1;
        end
        chk("rsp_single_pulse", 32'(rv1), 32'd0);
    endtask

    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        req(we, f3, a, wd, rd, er, lat);
        chk({tag, "_lat"},   32'(lat), 32'd1);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"},   32'(er), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] c1, c2, rdx;
        logic        erx;
        int          latx;

        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_funct3 = 3'b010; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready1), 32'd1);
        chk("rst_rsp_valid", 32'(rv1), 32'd0);
        chk("rst_rdata", rd1, 32'd0);
        chk("rst_err", 32'(re1), 32'd0);
        chk("rst_led", led1, 32'd0);
        chk("rst_ready_ws0", 32'(ready0), 32'd1);
        chk("rst_ready_ws3", 32'(ready3), 32'd1);
        rst = 1'b1;

        // Continuous requests: period 2 with no wait states, period 5 with three
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        for (int i = 0; i < 20; i++) begin
            chk("hs_ready_ws0", 32'(ready0), 32'(i % 2 == 0));
            chk("hs_valid_ws0", 32'(rv0),    32'(i % 2 == 1));
            chk("hs_ready_ws3", 32'(ready3), 32'(i % 5 == 0));
            chk("hs_valid_ws3", 32'(rv3),    32'(i % 5 == 4));
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        access("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        access("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        access("sw_20",  1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
        access("sb_22",  1'b1, 3'b000, 32'h22, 32'h000000AB, 32'h0, 1'b0);
        access("lw_20",  1'b0, 3'b010, 32'h20, 32'h0, 32'h11AB3344, 1'b0);
        access("lbu_22", 1'b0, 3'b100, 32'h22, 32'h0, 32'h000000AB, 1'b0);
        access("lb_22",  1'b0, 3'b000, 32'h22, 32'h0, 32'hFFFFFFAB, 1'b0);
        access("lb_20",  1'b0, 3'b000, 32'h20, 32'h0, 32'h00000044, 1'b0);

        access("lw_mis",   1'b0, 3'b010, 32'h21,   32'h0, 32'h0, 1'b1);
        access("lw_oor",   1'b0, 3'b010, 32'h2000, 32'h0, 32'h0, 1'b1);
        access("f3_011",   1'b0, 3'b011, 32'h20,   32'h0, 32'h0, 1'b1);
        access("sw_mis",   1'b1, 3'b010, 32'h22,   32'h0, 32'h0, 1'b1);
        access("sbu_st",   1'b1, 3'b100, 32'h20,   32'h0, 32'h0, 1'b1);
        access("sw_oor",   1'b1, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
        access("lw_20_chk",1'b0, 3'b010, 32'h20,   32'h0, 32'h11AB3344, 1'b0);
        access("sw_last",  1'b1, 3'b010, 32'hFFC,  32'hA5A5_5A5A, 32'h0, 1'b0);
        access("lw_last",  1'b0, 3'b010, 32'hFFC,  32'h0, 32'hA5A5_5A5A, 1'b0);

        // Accepts at posedge P1 and P8, so the counter reads differ by 7
        req(1'b0, 3'b010, MB, 32'h0, c1, erx, latx);
        chk("cnt1_err", 32'(erx), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        req(1'b0, 3'b010, MB, 32'h0, c2, erx, latx);
        chk("cnt2_err", 32'(erx), 32'd0);
        chk("cnt_delta", c2 - c1, 32'd7);
        access("sw_cnt",  1'b1, 3'b010, MB, 32'h5, 32'h0, 1'b0);

        access("sw_led",  1'b1, 3'b010, MB + 32'd4, 32'h000000FF, 32'h0, 1'b0);
        chk("led_sw", led1, 32'h000000FF);
        access("sb_led",  1'b1, 3'b000, MB + 32'd7, 32'h00000080, 32'h0, 1'b0);
        chk("led_sb", led1, 32'h800000FF);
        access("lw_led",  1'b0, 3'b010, MB + 32'd4, 32'h0, 32'h800000FF, 1'b0);
        access("lw_mmio_oor", 1'b0, 3'b010, MB + 32'd8, 32'h0, 32'h0, 1'b1);

        access("sw_30",  1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0);
        access("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Abandon a store while it sits in the wait state
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h30; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("midop_busy", 32'(ready1), 32'd0);
        rst = 1'b0;
        #1;
        chk("midop_ready", 32'(ready1), 32'd1);
        chk("midop_valid", 32'(rv1), 32'd0);
        chk("midop_rdata", rd1, 32'd0);
        chk("midop_err", 32'(re1), 32'd0);
        chk("midop_led", led1, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("midop_no_rsp", 32'(rv1), 32'd0);
        end
        rst = 1'b1;
        access("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the core's load/store requests over a valid/ready request channel and a single-cycle response pulse.
- Contains word-addressed data RAM plus two MMIO registers: a free-running cycle counter and a software-writable LED register.
- Inserts a configurable wait-state count, so core-side multi-cycle memory handling can be exercised against a realistic slave.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit RAM words; RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
WAIT_STATES, 1, idle cycles between request acceptance and response (0..15).
MMIO_BASE, 32'h0001_0000, byte address of cycle counter; LED register at MMIO_BASE+4.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_addr  input  32  byte address.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I width code: 000 byte signed, 100 byte unsigned, 010 word.
req_wdata  input  32  store data; byte stores use bits [7:0].
rsp_valid  output  1  one-cycle response pulse.
rsp_rdata  output  32  load data, valid when rsp_valid; 0 for stores and errors.
rsp_err  output  1  access error flag, valid when rsp_valid.
led_out  output  32  current LED register value.

Behaviour:
- Reset (rst low, async): FSM to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, led_out=0, cycle counter=0, wait counter=0. RAM contents not reset.
- FSM states IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at edge e0, capture addr/we/funct3/wdata.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- WAIT:
  - req_ready=0.
  - Stay for exactly WAIT_STATES cycles (down-counter loaded with WAIT_STATES-1), then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, during the cycle starting at edge e0+WAIT_STATES.
  - req_ready=0; return to IDLE unconditionally.
  - Next accept possible at edge e0+WAIT_STATES+2 at the earliest.
- Exactly one outstanding request. req_* inputs are ignored outside IDLE.
- Store commit and load data capture occur on the edge entering RESP. rsp_rdata and rsp_err are registered outputs.
- Byte addressing is little-endian; byte lane = addr[1:0]; RAM word index = addr[31:2].
- Loads:
  - lw returns the full word.
  - lbu zero-extends the selected byte.
  - lb sign-extends the selected byte.
- Stores:
  - sw writes all 4 bytes.
  - sb writes only the lane selected by addr[1:0] with wdata[7:0]; other bytes are untouched.
- Errors (rsp_err=1, rsp_rdata=0, no state change):
  - Word access with addr[1:0]!=0.
  - funct3 not in {000,100,010}.
  - Address outside both RAM and the two MMIO words.
  - Store with funct3=100.
- Cycle counter (MMIO_BASE):
  - 32-bit, increments every clock after reset and wraps 32'hFFFF_FFFF -> 0.
  - Read value is the counter at the RESP-entry edge.
  - Stores are ignored with no error.
- LED register (MMIO_BASE+4): read/write; byte stores update one lane; led_out reflects the update the cycle after commit.
- Reset asserted mid-transaction: the request is abandoned, a store not yet committed is dropped, no rsp_valid is produced, and the FSM restarts in IDLE.
- Simultaneous request during RESP is not accepted (req_ready=0); the requester must hold req_valid until it sees ready.

Test Plan:
- WAIT_STATES=1: sw addr 0x10 data 0xDEADBEEF accepted at edge e0 -> rsp_valid high only in cycle after e0+1, rsp_err=0; subsequent lw 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte ops: sw 0x20=0x11223344, sb 0x22 data 0xAB, then lw 0x20 -> 0x11AB3344; lbu 0x22 -> 0x000000AB; lb 0x22 -> 0xFFFFFFAB.
- Errors: lw 0x21 -> rsp_err=1, rdata=0; lw 0x0000_2000 with DEPTH_WORDS=1024 -> rsp_err=1; funct3=011 -> rsp_err=1; after each, lw 0x20 is unchanged.
- MMIO: two lw of MMIO_BASE accepted N cycles apart -> values differ by exactly N; sw MMIO_BASE+4=0x0000_00FF -> led_out=0x000000FF next cycle; sb MMIO_BASE+7 data 0x80 -> led_out=0x800000FF.
- Handshake: req_valid held high continuously with WAIT_STATES=0 -> accepts every 2 cycles, one rsp_valid pulse per accept; WAIT_STATES=3 -> one accept every 5 cycles.
- Reset mid-op: sw 0x30=0x12345678 accepted, rst low during WAIT -> no rsp_valid, outputs at reset values; lw 0x30 after release returns prior contents, not 0x12345678.
